// File: rtl/seq_match_ctrl_if.sv
// rtl/seq_match_ctrl_if.sv - control/data/status bundle for the sequence matcher
// Master drives pattern, strobes and symbols; slave returns hit and window status.

interface seq_match_ctrl_if #(
   parameter int SYM_W = 3,
   parameter int DEPTH = 5,
   parameter int CNT_W = 8
);
   logic                          load_i;
   logic [SYM_W*DEPTH-1:0]        pattern_i;
   logic                          clear_i;
   logic                          valid_i;
   logic [SYM_W-1:0]              data_i;
   logic                          mode_i;
   logic                          match_o;
   logic                          success_o;
   logic [CNT_W-1:0]              match_cnt_o;
   logic [$clog2(DEPTH+1)-1:0]    fill_o;

   modport master (
      output load_i, pattern_i, clear_i, valid_i, data_i, mode_i,
      input  match_o, success_o, match_cnt_o, fill_o
   );

   modport slave (
      input  load_i, pattern_i, clear_i, valid_i, data_i, mode_i,
      output match_o, success_o, match_cnt_o, fill_o
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - sliding-window pattern matcher with hit pulse, sticky flag and counter
// Overlapping (mode 0) or non-overlapping (mode 1) detection over the last DEPTH accepted symbols.

module seq_match_ctrl #(
   parameter int SYM_W = 3,
   parameter int DEPTH = 5,
   parameter int CNT_W = 8
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   seq_match_ctrl_if.slave bus
);
   localparam int                HIST_W    = SYM_W * DEPTH;
   localparam int                FILL_W    = $clog2(DEPTH + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [HIST_W-1:0] pattern_q, pattern_d;
   logic [HIST_W-1:0] hist_q, hist_d, hist_shift;
   logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              match_q, match_d;
   logic              success_q, success_d;
   logic              hit;

   always_comb begin
      pattern_d  = pattern_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      cnt_d      = cnt_q;
      success_d  = success_q;
      match_d    = 1'b0;
      hist_shift = {bus.data_i, hist_q[HIST_W-1:SYM_W]};
      fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      // The fill guard stops an all-zero pattern matching the cleared history.
      hit        = (hist_shift == pattern_q) && (fill_inc == FILL_FULL);

      if (bus.load_i || bus.clear_i) begin
         if (bus.load_i) begin
            pattern_d = bus.pattern_i;
         end
         hist_d    = '0;
         fill_d    = '0;
         cnt_d     = '0;
         success_d = 1'b0;
      end else if (bus.valid_i) begin
         hist_d = hist_shift;
         fill_d = fill_inc;
         if (hit) begin
            match_d   = 1'b1;
            success_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (bus.mode_i) begin
               fill_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pattern_q <= '0;
         hist_q    <= '0;
         fill_q    <= '0;
         cnt_q     <= '0;
         match_q   <= 1'b0;
         success_q <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         cnt_q     <= cnt_d;
         match_q   <= match_d;
         success_q <= success_d;
      end
   end

   assign bus.match_o     = match_q;
   assign bus.success_o   = success_q;
   assign bus.match_cnt_o = cnt_q;
   assign bus.fill_o      = fill_q;
endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
- Clocked, parametrised successor of the five-symbol pattern matcher.
- Compares a sliding window of the last DEPTH accepted symbols against a loadable DEPTH-symbol pattern. Reports a per-hit pulse, a sticky success flag and a saturating hit count.
- Supports overlapping and non-overlapping detection modes.
- Sits between the debounced switch/button front end (data strobe) and the LED/7-seg display logic.

Parameters:
- SYM_W, 3: bits per symbol.
- DEPTH, 5: pattern length in symbols (>=2).
- CNT_W, 8: width of the hit counter.

Ports:
- clk_i, input, 1: system clock; all state changes on the rising edge.
- rst_n_i, input, 1: reset, asynchronous, active-low.
- load_i, input, 1: capture pattern_i as the new target; restarts matching.
- pattern_i, input, SYM_W*DEPTH: target pattern; slice [SYM_W-1:0] is the first (oldest) symbol.
- clear_i, input, 1: synchronous clear of history, fill, success and count; pattern retained.
- valid_i, input, 1: data_i is accepted this cycle (single-cycle strobe per symbol).
- data_i, input, SYM_W: input symbol.
- mode_i, input, 1: 0 = overlapping, 1 = non-overlapping.
- match_o, output, 1: one-cycle pulse per detected hit.
- success_o, output, 1: sticky; set on the first hit.
- match_cnt_o, output, CNT_W: number of hits, saturating.
- fill_o, output, $clog2(DEPTH+1): symbols in the window, saturating at DEPTH.

Behaviour:
- Reset (rst_n_i low, asynchronous): pattern register, history and fill cleared to 0; match_o=0, success_o=0, match_cnt_o=0.
- History register hist (SYM_W*DEPTH bits), on an accepted symbol: hist_next = {data_i, hist[SYM_W*DEPTH-1:SYM_W]}. The newest symbol enters at the top; the oldest sits in slice 0.
- fill_next = min(fill+1, DEPTH).
- Hit condition: valid_i accepted AND hist_next == pattern register AND fill_next == DEPTH.
  - The fill guard blocks false hits against a zero pattern after reset or clear.
- Latency: match_o, success_o and match_cnt_o update on the same edge that accepts the completing symbol. match_o is high for exactly that following cycle.
- Overlapping mode (mode_i=0): fill stays at DEPTH after a hit, so every further accepted symbol can produce a hit.
- Non-overlapping mode (mode_i=1): on a hit, fill goes to 0 instead of DEPTH. History still shifts. The next hit needs DEPTH fresh symbols.
- mode_i is sampled per accepted symbol. Changing it mid-stream takes effect on the next accepted symbol.
- Counter: +1 per hit; holds at 2^CNT_W-1 and never wraps.
- success_o: set on a hit; cleared only by reset, clear_i or load_i.
- load_i: pattern register <= pattern_i; hist, fill, success_o and match_cnt_o cleared; match_o=0.
- clear_i: as load_i, but the pattern register is unchanged.
- Priority when strobes coincide: load_i > clear_i > valid_i. A symbol presented with load_i or clear_i is dropped.
- valid_i low: no state changes; match_o=0.
- Reset mid-stream: all state lost, including the pattern. Software must reload.

Test Plan (SYM_W=3, DEPTH=5):
- Reset, then load pattern 1,2,3,4,5 (pattern_i=15'o54321). Send 1,2,3,4 → no match_o, fill_o=4. Send 5 → match_o pulses 1 cycle, success_o=1, match_cnt_o=1.
- Pattern 1,1,1,1,1, mode 0, send seven 1s → hits on symbols 5,6,7, count=3. Repeat after clear_i in mode 1 → one hit on symbol 5 only, count=1, fill_o=2 at end.
- Pattern all zeros, after reset send nothing → no hit. Send four 0s → no hit. Fifth 0 → hit (fill guard verified).
- CNT_W=2, overlapping all-ones pattern, send ten 1s → count saturates at 3, match_o still pulses on each hit.
- Assert load_i together with valid_i (data 5) → symbol dropped, fill_o=0. Assert clear_i with valid_i → same, and the pattern is retained: resending 1..5 still hits.
- Assert rst_n_i low asynchronously between clock edges mid-sequence → outputs 0 immediately. Then send 1..5 without load → no hit (pattern 0).
